// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: default parameters and
// the FSM state encoding.
package sar_pkg;

    localparam int SAR_WIDTH_DEF      = 8;
    localparam int SAR_SAMPLE_CYC_DEF = 4;
    localparam int SAR_SETTLE_CYC_DEF = 2;

    typedef logic [2:0] sar_state_t;

    localparam sar_state_t ST_IDLE   = 3'd0;
    localparam sar_state_t ST_SAMPLE = 3'd1;
    localparam sar_state_t ST_SETTLE = 3'd2;
    localparam sar_state_t ST_DECIDE = 3'd3;
    localparam sar_state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track phase, then one settle/decide
// pass per bit from MSB down, committing the code in DONE.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH      = SAR_WIDTH_DEF,
    parameter int SAMPLE_CYC = SAR_SAMPLE_CYC_DEF,
    parameter int SETTLE_CYC = SAR_SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             cmp_async,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [7:0]       CNT_SAMPLE = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0]       CNT_SETTLE = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       CNT_ONE    = 8'd1;
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [WIDTH-1:0] CODE_MSB   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CODE_ZERO  = {WIDTH{1'b0}};

    sar_state_t       r_state;
    logic [7:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_sample;
    logic             r_busy;

    sar_state_t       w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_code_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_trial;
    logic             w_cmp;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (cmp_async),
        .o_q (w_cmp)
    );

    // Next-state logic; the single r_cnt times both the track and settle phases.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_trial      = r_code;
        case (r_state)
            ST_IDLE: begin
                w_code_nxt = CODE_ZERO;
                if (start && !abort) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = CNT_SAMPLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_ZERO;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_SETTLE;
                    w_idx_nxt   = IDX_TOP;
                    w_code_nxt  = CODE_MSB;
                    w_cnt_nxt   = CNT_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_ZERO;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_DECIDE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_DECIDE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = CODE_ZERO;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    if (!w_cmp) begin
                        w_trial[r_idx] = 1'b0;
                    end else begin
                        w_trial[r_idx] = 1'b1;
                    end
                    if (r_idx != IDX_ZERO) begin
                        w_trial[r_idx - IDX_ONE] = 1'b1;
                        w_idx_nxt   = r_idx - IDX_ONE;
                        w_cnt_nxt   = CNT_SETTLE;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                    w_code_nxt = w_trial;
                end
            end
            ST_DONE: begin
                // DONE always commits, even when aborted in this cycle.
                w_result_nxt = r_code;
                w_done_nxt   = 1'b1;
                w_code_nxt   = CODE_ZERO;
                if (cont && !abort) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = CNT_SAMPLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = CODE_ZERO;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and output registers; outputs decode the next state so they are flop-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_idx    <= IDX_ZERO;
            r_code   <= CODE_ZERO;
            r_result <= CODE_ZERO;
            r_done   <= 1'b0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            r_sample <= (w_state_nxt == ST_SAMPLE);
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sample   = r_sample;
    assign dac_code = r_code;
    assign busy     = r_busy;
    assign result   = r_result;
    assign done     = r_done;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with a behavioural comparator model
// (cmp = Vin >= dac_code, or tied high/low).
module tb_sar_adc_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       abort;
    logic       cmp_async;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic [7:0] result;
    logic       done;

    logic [7:0] vin;
    logic [1:0] cmp_mode;   // 0: compare, 1: tied 1, 2: tied 0

    int n_tests;
    int n_fail;

    sar_adc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .cmp_async (cmp_async),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .result    (result),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (cmp_mode)
            2'd1:    cmp_async = 1'b1;
            2'd2:    cmp_async = 1'b0;
            default: cmp_async = (vin >= dac_code);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start edge must already have been clocked; counts clocks to the done pulse.
    task automatic wait_done(output int cyc, output int ns);
        cyc = 0;
        ns  = int'(sample);
        while (cyc < 100) begin
            tick();
            cyc++;
            if (done) break;
            ns += int'(sample);
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt += int'(done);
        end
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int cyc;
    int ns;
    int nd;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        abort    = 1'b0;
        vin      = 8'h00;
        cmp_mode = 2'd0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dac", {24'd0, dac_code}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_sample", {31'd0, sample}, 32'd0);

        // Basic conversion
        vin = 8'hA5;
        kick();
        check("a5_sample0", {31'd0, sample}, 32'd1);
        wait_done(cyc, ns);
        check("a5_latency", cyc, 32'd29);
        check("a5_nsample", ns, 32'd4);
        check("a5_result", {24'd0, result}, 32'hA5);
        check("a5_busy", {31'd0, busy}, 32'd0);
        tick();
        check("a5_done_pulse", {31'd0, done}, 32'd0);

        // Comparator tied high / low
        cmp_mode = 2'd1;
        kick();
        wait_done(cyc, ns);
        check("t1_latency", cyc, 32'd29);
        check("t1_result", {24'd0, result}, 32'hFF);
        cmp_mode = 2'd2;
        kick();
        wait_done(cyc, ns);
        check("t0_latency", cyc, 32'd29);
        check("t0_result", {24'd0, result}, 32'h00);
        cmp_mode = 2'd0;

        // Continuous mode, cont cleared during the second conversion
        cont = 1'b1;
        vin  = 8'h3C;
        kick();
        wait_done(cyc, ns);
        check("c1_latency", cyc, 32'd29);
        check("c1_nsample", ns, 32'd4);
        check("c1_result", {24'd0, result}, 32'h3C);
        check("c1_restart", {31'd0, sample}, 32'd1);
        vin  = 8'hC3;
        cont = 1'b0;
        wait_done(cyc, ns);
        check("c2_period", cyc, 32'd29);
        check("c2_nsample", ns, 32'd4);
        check("c2_result", {24'd0, result}, 32'hC3);
        check("c2_stop", {31'd0, busy}, 32'd0);

        // Abort at clock 12
        vin = 8'h11;
        kick();
        for (int i = 0; i < 11; i++) tick();
        check("ab_busy_pre", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_dac", {24'd0, dac_code}, 32'd0);
        check("ab_result", {24'd0, result}, 32'hC3);
        check("ab_done", {31'd0, done}, 32'd0);
        count_done(40, nd);
        check("ab_no_done", nd, 32'd0);

        // Abort with start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abst_busy", {31'd0, busy}, 32'd0);

        // Abort in DONE still commits, ignores cont
        cont = 1'b1;
        vin  = 8'h6E;
        kick();
        for (int i = 0; i < 28; i++) tick();
        check("abd_not_yet", {31'd0, done}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cont  = 1'b0;
        check("abd_done", {31'd0, done}, 32'd1);
        check("abd_result", {24'd0, result}, 32'h6E);
        check("abd_busy", {31'd0, busy}, 32'd0);
        count_done(35, nd);
        check("abd_no_more", nd, 32'd0);

        // Reset at clock 15
        vin = 8'h11;
        kick();
        for (int i = 0; i < 14; i++) tick();
        rst = 1'b1;
        #1;
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_dac", {24'd0, dac_code}, 32'd0);
        check("rs_result", {24'd0, result}, 32'd0);
        check("rs_sample", {31'd0, sample}, 32'd0);
        tick();
        rst = 1'b0;
        count_done(35, nd);
        check("rs_no_done", nd, 32'd0);
        vin = 8'h5A;
        kick();
        wait_done(cyc, ns);
        check("rs_latency", cyc, 32'd29);
        check("rs_result2", {24'd0, result}, 32'h5A);

        // Start held high through a conversion, cont=0
        vin   = 8'h77;
        start = 1'b1;
        tick();
        wait_done(cyc, ns);
        check("sh1_latency", cyc, 32'd29);
        check("sh1_result", {24'd0, result}, 32'h77);
        check("sh1_idle", {31'd0, busy}, 32'd0);
        vin = 8'h2B;
        tick();
        check("sh2_begin", {31'd0, sample}, 32'd1);
        wait_done(cyc, ns);
        start = 1'b0;
        check("sh2_latency", cyc, 32'd29);
        check("sh2_result", {24'd0, result}, 32'h2B);
        count_done(40, nd);
        check("sh2_no_extra", nd, 32'd0);
        check("sh2_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
